// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and opcode constants for the multicycle control path
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } class_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic    fetch;
    logic    mem_req;
    logic    mem_we;
    logic    ir_we;
    logic    pc_we;
    pc_src_t pc_src;
    logic    rf_we;
    wb_sel_t wb_sel;
    logic    alu_src_b;
    logic    retire;
  } ctrl_t;

  // Unqualified Moore controls; handshake-dependent strobes are gated in the top.
  function automatic ctrl_t moore_ctrl(input state_t s, input class_t c);
    ctrl_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.fetch   = 1'b1;
        o.mem_req = 1'b1;
        o.ir_we   = 1'b1;
        o.pc_we   = 1'b1;
        o.pc_src  = PC_PLUS4;
      end
      EXEC: begin
        o.alu_src_b = !(c == CLS_OP || c == CLS_BRANCH);
        case (c)
          CLS_BRANCH: begin
            o.pc_we  = 1'b1;
            o.pc_src = PC_TARGET;
            o.retire = 1'b1;
          end
          CLS_JAL: begin
            o.pc_we  = 1'b1;
            o.pc_src = PC_TARGET;
          end
          CLS_JALR: begin
            o.pc_we  = 1'b1;
            o.pc_src = PC_JALR;
          end
          default: ;
        endcase
      end
      MEM: begin
        o.mem_req = 1'b1;
        o.mem_we  = (c == CLS_STORE);
        o.retire  = (c == CLS_STORE);
      end
      WB: begin
        o.rf_we  = 1'b1;
        o.retire = 1'b1;
        if (c == CLS_LOAD)
          o.wb_sel = WB_LOAD;
        else if (c == CLS_JAL || c == CLS_JALR)
          o.wb_sel = WB_PC4;
        else
          o.wb_sel = WB_ALU;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - maps a 7-bit RV32I opcode to its instruction class
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] cls,
  output logic       valid
);

  always_comb begin
    cls   = CLS_NONE;
    valid = 1'b1;
    case (opcode)
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OP:     cls = CLS_OP;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with trap and instret
module multicycle_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             fetch,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t            state_q, state_d;
  class_t            cls_q, cls_d;
  ctrl_t             ctrl_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  instret_q;
  logic              illegal_q;
  logic [3:0]        dec_cls_raw;
  logic              dec_valid;
  logic              waiting;
  logic              wait_hit;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (dec_cls_raw),
    .valid  (dec_valid)
  );

  assign waiting  = (state_q == FETCH || state_q == MEM) && !mem_ready;
  assign wait_hit = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      FETCH: begin
        if (mem_ready)
          state_d = DECODE;
        else if (wait_hit)
          state_d = TRAP;
      end
      DECODE: begin
        cls_d   = class_t'(dec_cls_raw);
        state_d = dec_valid ? EXEC : TRAP;
      end
      EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = FETCH;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          default:             state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready)
          state_d = (cls_q == CLS_STORE) ? FETCH : WB;
        else if (wait_hit)
          state_d = TRAP;
      end
      WB:      state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end

  // Controls are registered for the state being entered, so they are glitch-free next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      cls_q      <= CLS_NONE;
      ctrl_q     <= moore_ctrl(FETCH, CLS_NONE);
      wait_cnt_q <= '0;
      instret_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ctrl_q  <= moore_ctrl(state_d, cls_d);
      if (state_d != state_q)
        wait_cnt_q <= '0;
      else if (waiting && wait_cnt_q != WAIT_W'(MEM_WAIT_MAX))
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      if (retire)
        instret_q <= instret_q + CNT_W'(1);
      if (state_d == TRAP)
        illegal_q <= 1'b1;
    end
  end

  // Reset forces the idle pattern immediately so an aborted instruction emits no strobes.
  always_comb begin
    fetch     = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_b = 1'b0;
    retire    = 1'b0;
    if (!rst) begin
      fetch     = ctrl_q.fetch;
      mem_req   = ctrl_q.mem_req;
      mem_we    = ctrl_q.mem_we;
      pc_src    = ctrl_q.pc_src;
      rf_we     = ctrl_q.rf_we;
      wb_sel    = ctrl_q.wb_sel;
      alu_src_b = ctrl_q.alu_src_b;
      ir_we     = ctrl_q.ir_we && mem_ready;
      case (state_q)
        FETCH:   pc_we = ctrl_q.pc_we && mem_ready;
        EXEC:    pc_we = ctrl_q.pc_we && (cls_q != CLS_BRANCH || branch_taken);
        default: pc_we = ctrl_q.pc_we;
      endcase
      retire = ctrl_q.retire && (state_q != MEM || mem_ready);
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed and randomized checks of the multicycle control FSM
module tb_multicycle_ctrl_fsm;

  localparam int CNT_W = 32;
  localparam int WMAX  = 15;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;
  localparam int C_BAD = 0, C_LOAD = 1, C_STORE = 2, C_OP = 3, C_OPIMM = 4;
  localparam int C_BRANCH = 5, C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             fetch, mem_req, mem_we, ir_we, pc_we, rf_we, alu_src_b, retire, illegal;
  logic [1:0]       pc_src, wb_sel;
  logic [CNT_W-1:0] instret;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [12:0]      obs;
  logic [6:0]       legal [9];

  assign obs = {fetch, mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
                alu_src_b, retire, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .MEM_WAIT_MAX(WMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .fetch        (fetch),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_src_b    (alu_src_b),
    .retire       (retire),
    .instret      (instret),
    .illegal      (illegal)
  );

  function automatic int cls_of(input logic [6:0] opc);
    case (opc)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_OP;
      7'b0010011: return C_OPIMM;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_BAD;
    endcase
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // One clock of one phase: expected controls follow directly from the phase's rules.
  task automatic step(input int ph, input int c, input logic [6:0] opc, input bit mr,
                      input bit bt, input string tag);
    bit f, mq, mw, iw, pw, rw, ab, rt, il;
    logic [1:0] pcs, wbs;
    logic [12:0] e;
    {f, mq, mw, iw, pw, rw, ab, rt, il} = '0;
    pcs = 2'd0;
    wbs = 2'd0;
    case (ph)
      P_F: begin f = 1; mq = 1; iw = mr; pw = mr; end
      P_E: begin
        ab = !(c == C_OP || c == C_BRANCH);
        if (c == C_BRANCH) begin pw = bt; pcs = 2'd1; rt = 1; end
        if (c == C_JAL)    begin pw = 1;  pcs = 2'd1; end
        if (c == C_JALR)   begin pw = 1;  pcs = 2'd2; end
      end
      P_M: begin mq = 1; mw = (c == C_STORE); rt = (c == C_STORE) && mr; end
      P_W: begin
        rw = 1;
        rt = 1;
        wbs = (c == C_LOAD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
      end
      P_T: il = 1;
      default: ;
    endcase
    opcode       = (ph == P_F) ? 7'($urandom()) : opc;
    mem_ready    = (ph == P_F || ph == P_M) ? mr : 1'($urandom());
    branch_taken = (ph == P_E) ? bt : 1'($urandom());
    @(negedge clk);
    e = {f, mq, mw, iw, pw, pcs, rw, wbs, ab, rt, il};
    check_vec(tag, obs, e);
    check_cnt({tag, "_instret"}, instret, exp_instret);
    if (rt) exp_instret = exp_instret + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input int fwait, input int mwait,
                           input bit bt, input string tag, output bit trapped);
    int c;
    c = cls_of(opc);
    trapped = 1'b1;
    for (int i = 0; i < fwait && i < WMAX; i++) step(P_F, c, opc, 1'b0, bt, tag);
    if (fwait >= WMAX) begin step(P_T, c, opc, 1'b0, bt, tag); return; end
    step(P_F, c, opc, 1'b1, bt, tag);
    step(P_D, c, opc, 1'b0, bt, tag);
    if (c == C_BAD) begin step(P_T, c, opc, 1'b0, bt, tag); return; end
    step(P_E, c, opc, 1'b0, bt, tag);
    trapped = 1'b0;
    if (c == C_BRANCH) return;
    if (c == C_LOAD || c == C_STORE) begin
      for (int i = 0; i < mwait && i < WMAX; i++) step(P_M, c, opc, 1'b0, bt, tag);
      if (mwait >= WMAX) begin
        trapped = 1'b1;
        step(P_T, c, opc, 1'b0, bt, tag);
        return;
      end
      step(P_M, c, opc, 1'b1, bt, tag);
      if (c == C_STORE) return;
    end
    step(P_W, c, opc, 1'b0, bt, tag);
  endtask

  // Two reset cycles; the first checks that whatever was in flight emits no strobes.
  task automatic do_reset(input string tag);
    rst          = 1'b1;
    opcode       = 7'($urandom());
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    check_vec({tag, "_abort"}, {obs[12:1], 1'b0}, 13'h1000);
    @(posedge clk);
    #1;
    mem_ready = 1'($urandom());
    @(negedge clk);
    check_vec({tag, "_rst"}, obs, 13'h1000);
    check_cnt({tag, "_rst_instret"}, instret, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = '0;
  endtask

  initial begin
    bit tr;
    logic [6:0] opc;
    int fw, mw;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    @(posedge clk);
    #1;
    do_reset("init");

    run_instr(7'b0110011, 0, 0, 1'b0, "add", tr);
    run_instr(7'b0000011, 0, 3, 1'b0, "lw_wait", tr);
    run_instr(7'b1100011, 0, 0, 1'b1, "beq_taken", tr);
    run_instr(7'b1100011, 0, 0, 1'b0, "beq_not", tr);
    run_instr(7'b0100011, 2, 0, 1'b0, "sw", tr);
    run_instr(7'b1100111, 0, 0, 1'b0, "jalr", tr);

    run_instr(7'b0000000, 0, 0, 1'b0, "illop", tr);
    for (int i = 0; i < 19; i++) step(P_T, C_BAD, 7'b0000000, 1'b0, 1'b0, "illop_hold");
    do_reset("illop");

    run_instr(7'b0110011, WMAX, 0, 1'b0, "fetch_timeout", tr);
    for (int i = 0; i < 3; i++) step(P_T, C_OP, 7'b0110011, 1'b0, 1'b0, "fetch_timeout_hold");
    do_reset("fetch_timeout");

    step(P_F, C_JAL, 7'b1101111, 1'b1, 1'b0, "abort_f");
    step(P_D, C_JAL, 7'b1101111, 1'b0, 1'b0, "abort_d");
    do_reset("abort");

    force dut.instret_q = {CNT_W{1'b1}};
    #1;
    release dut.instret_q;
    exp_instret = {CNT_W{1'b1}};
    run_instr(7'b0010011, 0, 0, 1'b0, "wrap", tr);
    step(P_F, C_OP, 7'b0110011, 1'b1, 1'b0, "wrap_after");
    do_reset("post_wrap");

    for (int n = 0; n < 150; n++) begin
      opc = legal[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) opc = 7'($urandom());
      fw = ($urandom_range(0, 29) == 0) ? WMAX : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 29) == 0) ? WMAX : int'($urandom_range(0, 6));
      run_instr(opc, fw, mw, 1'($urandom()), "rand", tr);
      if (tr) do_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle control state machine for the RV32I core.
- Sequences every instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the `fetch` select of the downstream 5-bit register-address mux: fetch=1 selects in_a, fetch=0 selects in_b.
- Also generates all datapath write enables, the memory request handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the instret counter.
- MEM_WAIT_MAX, 15, max cycles to wait for mem_ready before entering TRAP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- branch_taken  in  1  ALU compare result; sampled in EXEC.
- mem_ready  in  1  memory handshake; completes the current mem_req.
- fetch  out  1  1 only in FETCH; drives the 5-bit address mux select.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  store request; qualifies mem_req in MEM.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  0=pc+4, 1=branch/jal target, 2=jalr target.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  0=ALU, 1=load data, 2=pc+4.
- alu_src_b  out  1  0=rs2, 1=immediate.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  sticky; set on unknown opcode or memory timeout.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- While rst=1, on the next edge:
  - state←FETCH; instret←0; illegal←0; wait counter←0; latched class←NONE.
  - Outputs during rst: fetch=1, all strobes/mem_req/mem_we/retire=0, pc_src=0, wb_sel=0, alu_src_b=0.
- Outputs are Moore-decoded from state and the latched class. Exceptions: ir_we and pc_we in FETCH are qualified by mem_ready.
- FETCH:
  - fetch=1, mem_req=1, mem_we=0.
  - If mem_ready: ir_we=1, pc_we=1 (pc_src=0), go to DECODE.
  - Else stay; wait counter increments. When it reaches MEM_WAIT_MAX, go to TRAP.
- DECODE:
  - fetch=0. Classify opcode and latch the class.
  - Classes: LOAD 0000011, STORE 0100011, OP 0110011, OPIMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode goes to TRAP; otherwise EXEC.
- EXEC:
  - alu_src_b=1 for all classes except OP/BRANCH.
  - BRANCH: pc_we=branch_taken, pc_src=1, retire=1, go to FETCH.
  - JAL/JALR: pc_we=1, pc_src=1/2, go to WB.
  - LOAD/STORE: go to MEM.
  - Others: go to WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE.
  - If mem_ready: STORE retires and goes to FETCH; LOAD goes to WB.
  - Else wait with the same timeout rule as FETCH.
- WB:
  - rf_we=1, retire=1, go to FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
- TRAP:
  - Absorbing until rst. illegal=1; all strobes and mem_req=0; fetch=0.
- Latency with mem_ready=1 throughout:
  - OP/OPIMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Wait counter:
  - Clears on every state change.
  - Saturates; does not wrap.
- instret:
  - Increments on retire.
  - Wraps modulo 2^CNT_W.
- rst asserted mid-instruction (any state) aborts it: no retire, no strobes that cycle.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- cpu_pkg holds:
  - state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}.
  - opcode localparams.
  - class_t enum.
  - pc_src_t and wb_sel_t enums.
- One sub-module: opcode_classifier, combinational, opcode → class_t plus a valid flag.

Test Plan:
- Reset: hold rst 2 cycles → fetch=1, instret=0, illegal=0, rf_we=0, mem_req=0.
- ADD (0110011), mem_ready=1 → states F,D,E,W; rf_we in cycle 4; retire pulses once; instret=1; fetch=1 only in cycle 1.
- LW (0000011), mem_ready low 3 cycles in MEM → MEM held 4 cycles with mem_req=1 and mem_we=0; rf_we with wb_sel=1; 8 cycles total.
- BEQ (1100011), branch_taken=1, then branch_taken=0 → first: pc_we=1, pc_src=1 in EXEC; second: pc_we=0 in EXEC; both 3 cycles; instret+=2.
- Opcode 0000000 → TRAP after DECODE; illegal=1 persists 20 cycles; no mem_req; rst clears it.
- mem_ready held low in FETCH → TRAP after 15 wait cycles.
- instret preset to all-ones via force, retire one instruction → instret wraps to 0.
